// File: rtl/image_downsampler.sv
// 2:1 image downsampler: host loads a source frame, triggers processing, reads back the half-size
// frame. Define DS_AVG_EN for a rounded 2x2 box average; otherwise the top-left pixel is kept.
module image_downsampler #(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        status,
    input  logic [PIX_W-1:0]  data,
    input  logic [ADDR_W-1:0] addr,
    output logic              end_process,
    output logic              busy,
    output logic [PIX_W-1:0]  out
);

    localparam int unsigned SRC_N  = IMG_W * IMG_H;
    localparam int unsigned DST_N  = SRC_N / 4;
    localparam int unsigned SRC_AW = $clog2(SRC_N);
    localparam int unsigned DST_AW = SRC_AW - 2;
    localparam int unsigned XW     = $clog2(IMG_W / 2);
`ifdef DS_AVG_EN
    localparam int unsigned ACC_W  = PIX_W + 2;
`else
    localparam int unsigned ACC_W  = PIX_W;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StProc, StDone} state_e;

    state_e              state_q;
    logic [2:0]          phase_q;
    logic [DST_AW-1:0]   pix_q;
    logic [ACC_W-1:0]    acc_q;
    logic [PIX_W-1:0]    src_rdata_q;
    logic [PIX_W-1:0]    src_mem [SRC_N];
    logic [PIX_W-1:0]    dst_mem [DST_N];

    logic                src_we;
    logic                dst_we;
    logic                rd_en;
    logic                last_pix;
    logic [SRC_AW-1:0]   src_raddr;
    logic [PIX_W-1:0]    result;
`ifdef DS_AVG_EN
    logic [ACC_W-1:0]    sum;
`endif

    always_comb begin
        src_we   = (state_q != StProc) && (status == 2'b10) && (32'(addr) < SRC_N);
        rd_en    = (state_q != StProc) && (status == 2'b11);
        dst_we   = (state_q == StProc) && (phase_q == 3'd4);
        last_pix = (pix_q == DST_AW'(DST_N - 1));
        // Phase bit 0 picks the right column, bit 1 the lower row of the 2x2 block.
        src_raddr = {pix_q[DST_AW-1:XW], phase_q[1], pix_q[XW-1:0], phase_q[0]};
`ifdef DS_AVG_EN
        sum    = acc_q + ACC_W'(src_rdata_q) + ACC_W'(2);
        result = sum[ACC_W-1:2];
`else
        result = acc_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (src_we) begin
            src_mem[addr[SRC_AW-1:0]] <= data;
        end
        src_rdata_q <= src_mem[src_raddr];
        if (dst_we) begin
            dst_mem[pix_q] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= 3'd0;
            pix_q       <= '0;
            acc_q       <= '0;
            busy        <= 1'b0;
            end_process <= 1'b0;
            out         <= '0;
        end else begin
            if (rd_en) begin
                out <= (32'(addr) < DST_N) ? dst_mem[addr[DST_AW-1:0]] : '0;
            end
            unique case (state_q)
                StIdle, StLoad: begin
                    if (status == 2'b01) begin
                        state_q <= StProc;
                        busy    <= 1'b1;
                        phase_q <= 3'd0;
                        pix_q   <= '0;
                        acc_q   <= '0;
                    end else if (status == 2'b10) begin
                        state_q <= StLoad;
                    end
                end
                StProc: begin
                    // Read data lags the issued address by one cycle: a arrives in phase 1.
                    if (phase_q == 3'd1) begin
                        acc_q <= ACC_W'(src_rdata_q);
                    end
`ifdef DS_AVG_EN
                    else if (phase_q == 3'd2 || phase_q == 3'd3) begin
                        acc_q <= acc_q + ACC_W'(src_rdata_q);
                    end
`endif
                    if (phase_q == 3'd4) begin
                        phase_q <= 3'd0;
                        pix_q   <= pix_q + 1'b1;
                        if (last_pix) begin
                            state_q     <= StDone;
                            busy        <= 1'b0;
                            end_process <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 3'd1;
                    end
                end
                StDone: begin
                    if (status == 2'b10) begin
                        state_q     <= StLoad;
                        end_process <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_image_downsampler.sv
// Scoreboard bench for image_downsampler on a 16x8, 10-bit frame; follows DS_AVG_EN like the DUT.
module tb_image_downsampler;

    localparam int W     = 16;
    localparam int H     = 8;
    localparam int P     = 10;
    localparam int AW    = 8;
    localparam int SRC_N = W * H;
    localparam int DST_N = SRC_N / 4;
    localparam int PROC_CYCLES = 5 * DST_N;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    status;
    logic [P-1:0]  data;
    logic [AW-1:0] addr;
    logic          end_process;
    logic          busy;
    logic [P-1:0]  out;

    int errors = 0;
    int checks = 0;

    logic [P-1:0] src_m [SRC_N];
    logic [P-1:0] dst_m [DST_N];
    logic [P-1:0] exp_q [$];

    image_downsampler #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (P),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .status     (status),
        .data       (data),
        .addr       (addr),
        .end_process(end_process),
        .busy       (busy),
        .out        (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: each output pixel from its 2x2 source block with plain integer arithmetic.
    task automatic model_frame();
        for (int oy = 0; oy < H / 2; oy++) begin
            for (int ox = 0; ox < W / 2; ox++) begin
                int a, b, c, d;
                a = int'(src_m[(2 * oy) * W + 2 * ox]);
                b = int'(src_m[(2 * oy) * W + 2 * ox + 1]);
                c = int'(src_m[(2 * oy + 1) * W + 2 * ox]);
                d = int'(src_m[(2 * oy + 1) * W + 2 * ox + 1]);
`ifdef DS_AVG_EN
                dst_m[oy * (W / 2) + ox] = P'((a + b + c + d + 2) / 4);
`else
                dst_m[oy * (W / 2) + ox] = P'(a);
`endif
            end
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < SRC_N; i++) src_m[i] = P'($urandom_range(0, (1 << P) - 1));
    endtask

    task automatic load_frame();
        for (int i = 0; i < SRC_N; i++) begin
            @(negedge clk);
            status = 2'b10;
            addr   = AW'(i);
            data   = src_m[i];
        end
        // Beyond the source frame: must be dropped, not aliased onto src[72].
        @(negedge clk);
        addr = 8'd200;
        data = ~src_m[72];
        @(negedge clk);
        status = 2'b00;
        addr   = '0;
    endtask

    task automatic run_proc(output int n);
        @(negedge clk);
        status = 2'b01;
        @(negedge clk);
        status = 2'b00;
        check("busy_rise", busy, 1);
        check("end_low_in_proc", end_process, 0);
        n = 0;
        while (end_process !== 1'b1 && n < 4 * PROC_CYCLES) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall_with_end", busy, 0);
    endtask

    task automatic read_px(input int a, input logic [P-1:0] expv);
        @(negedge clk);
        status = 2'b11;
        addr   = AW'(a);
        exp_q.push_back(expv);
    endtask

    task automatic read_all();
        for (int i = 0; i < DST_N; i++) read_px(i, dst_m[i]);
        read_px(DST_N + 8, '0);
        read_px(255, '0);
        @(negedge clk);
        status = 2'b00;
    endtask

    // Monitor: every sampled read command yields a registered pixel one edge later.
    initial begin
        logic [P-1:0] e;
        forever begin
            @(posedge clk);
            if (status == 2'b11 && rst !== 1'b1) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexpected: got %0d, expected no read", out);
                end else begin
                    e = exp_q.pop_front();
                    check("read_pixel", out, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        status = 2'b00;
        data   = '0;
        addr   = '0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_end", end_process, 0);
        check("reset_out", out, 0);

        // Constant frame
        for (int i = 0; i < SRC_N; i++) src_m[i] = 10'h040;
        model_frame();
        load_frame();
        run_proc(n);
        check("proc_cycles_const", n, PROC_CYCLES);
        read_all();

        // Process command in DONE is ignored
        @(negedge clk);
        status = 2'b01;
        @(negedge clk);
        status = 2'b00;
        check("done_ignores_proc_end", end_process, 1);
        check("done_ignores_proc_busy", busy, 0);

        // Output holds when not reading
        read_px(3, dst_m[3]);
        @(negedge clk);
        status = 2'b00;
        addr   = 8'd5;
        @(negedge clk);
        check("out_hold", out, 32'(dst_m[3]));

        // Random frame with known blocks at outputs 0..2
        random_frame();
        src_m[0] = 10;   src_m[1] = 11;   src_m[16] = 12;  src_m[17] = 13;
        src_m[2] = 1023; src_m[3] = 1023; src_m[18] = 1023; src_m[19] = 1023;
        src_m[4] = 1023; src_m[5] = 0;    src_m[20] = 0;    src_m[21] = 0;
        model_frame();
        load_frame();
        check("end_cleared_by_load", end_process, 0);
        run_proc(n);
        check("proc_cycles_rand", n, PROC_CYCLES);
        read_all();
`ifdef DS_AVG_EN
        read_px(0, 10'd12);
        read_px(1, 10'd1023);
        read_px(2, 10'd256);
`else
        read_px(0, 10'd10);
        read_px(1, 10'd1023);
        read_px(2, 10'd1023);
`endif
        @(negedge clk);
        status = 2'b00;

        // Reset in the middle of processing
        random_frame();
        load_frame();
        @(negedge clk);
        status = 2'b01;
        @(negedge clk);
        status = 2'b00;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_end", end_process, 0);
        check("abort_out", out, 0);

        random_frame();
        model_frame();
        load_frame();
        run_proc(n);
        check("proc_cycles_after_abort", n, PROC_CYCLES);
        read_all();

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_downsampler.md
# image_downsampler

Parametrised 2:1 image downsampling engine, the successor to the fixed 256x256 / 8-bit `machine` processing core. Host loads a source frame pixel-by-pixel, triggers processing, polls `end_process`, then reads back the half-resolution frame by address. Frame size, pixel width and address width are parameters. The block adds a synchronous reset and a `busy` flag. The filter (2x2 box average or decimation) is selected at compile time.

## Interface
- `IMG_W`, 256, source width in pixels; even power of two
- `IMG_H`, 256, source height in pixels; even
- `PIX_W`, 8, pixel bit width
- `ADDR_W`, 16, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `status`  in  2  command: 2'b00 idle, 2'b10 load, 2'b01 process, 2'b11 read
- `data`  in  PIX_W  source pixel to write during load
- `addr`  in  ADDR_W  linear row-major address (source in load, destination in read)
- `end_process`  out  1  high while processing has completed (DONE state)
- `busy`  out  1  high while in PROC state
- `out`  out  PIX_W  registered destination pixel in read mode

## Operation
- Storage: source RAM of IMG_W*IMG_H words; separate destination RAM of (IMG_W/2)*(IMG_H/2) words; both PIX_W wide. `rst` does not clear RAM contents.
- FSM states and transitions:
  - IDLE: status 10 -> LOAD; status 01 -> PROC.
  - LOAD: status 01 -> PROC.
  - PROC: runs to completion, then -> DONE. Status is not sampled in PROC.
  - DONE: status 10 -> LOAD. Status 01 -> stays DONE; re-running requires a load first.
- Load: in any non-PROC state, when status==10 and addr < IMG_W*IMG_H, write src[addr] <= data each cycle. Out-of-range writes are dropped. Writes in PROC are ignored.
- Process: output pixel (ox,oy) is produced from source pixels a=(2ox,2oy), b=(2ox+1,2oy), c=(2ox,2oy+1), d=(2ox+1,2oy+1). Result goes to dst[oy*(IMG_W/2)+ox]. Output pixels are processed in row-major order starting at 0.
- Arithmetic: sum is PIX_W+2 bits; result = (a+b+c+d+2)>>2, no overflow possible (see Configuration).
- Read: in any non-PROC state, when status==11, out <= dst[addr] if addr < (IMG_W/2)*(IMG_H/2), else 0. In other states and statuses, out holds its value.

## Timing
- Reset values: state IDLE, `end_process`=0, `busy`=0, `out`=0, internal counters 0.
- Per output pixel, exactly 5 cycles: cycles 0-3 issue source reads a,b,c,d; the RAM has 1-cycle read latency; the accumulator adds each return; cycle 4 writes dst.
- Total PROC duration: 5*(IMG_W/2)*(IMG_H/2) cycles, i.e. 81920 for the defaults.
- `busy` rises the cycle after status 01 is sampled in IDLE/LOAD. `end_process` rises the cycle after the final dst write, in the same cycle `busy` falls.
- `end_process` is a level signal. It stays high until a load command or `rst`.
- Read latency: `out` is valid 1 cycle after addr/status are sampled.
- `rst` mid-PROC aborts the run. Next cycle: IDLE with all outputs 0. The dst contents are then partially updated, with no defined content.

## Configuration
- `DS_AVG_EN` defined: 2x2 box average with round-half-up, as in Operation.
- `DS_AVG_EN` undefined: decimation, result = a (top-left pixel). The adder is removed. Cycle timing stays identical (5 cycles/pixel) so benches do not change.

## Test plan
- Constant frame: load all 8'h40 (defaults), process -> `end_process` high exactly 81920 cycles after `busy` rises; every out reads 8'h40.
- Known block: src[0]=10, src[1]=11, src[256]=12, src[257]=13 -> out at addr 0 = 12 with `DS_AVG_EN`, 10 without.
- Saturation: a 2x2 block of all 8'hFF -> 8'hFF (no wrap). A block 8'hFF,0,0,0 -> 64 with `DS_AVG_EN`.
- Out-of-range: read addr 16384 -> out 0. Load write at addr >= 65536 (with IMG_H=128, addr 32768) -> no src change.
- Reset mid-process: assert `rst` 1000 cycles into PROC -> next cycle `busy`=0, `end_process`=0, `out`=0. Reload and process -> correct result.
- Param sweep IMG_W=16, IMG_H=8, PIX_W=10: ramp load -> 5*32=160 cycle PROC; every output matches the reference model.
